lsu_port_arbiter: RTL and testbench

LSU_PORT_ARBITER -- requirements
Module: lsu_port_arbiter

---
 rtl/lsu_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_lsu_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares one LSU memory port between the CPU MEM stage and a
// debug/loader master.
//
// Ports
//   i_clk, i_reset          clock; synchronous active-low reset
//   i_cpu_*                 CPU access request and attributes
//   o_cpu_rdata             LSU read data passed straight through to the CPU
//   o_cpu_stall             pipeline freeze while the CPU is refused the port
//   i_dbg_valid/o_dbg_ready debug request handshake (word accesses only)
//   i_dbg_*                 debug access attributes
//   o_dbg_rdata/o_dbg_rvalid debug read response, one cycle after acceptance
//   o_mem_*, i_mem_rdata    shared LSU port (read data one cycle after address)
//
// Configuration
//   LSU_ARB_RR_EN  undefined: CPU wins ties unless debug has lost STARVE_MAX
//                  cycles in a row.
//                  defined:   ties alternate between requesters.
module lsu_port_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wren,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [2:0]  i_cpu_funct3,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_dbg_valid,
  output logic        o_dbg_ready,
  input  logic        i_dbg_wren,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dbg_rvalid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wren,
  output logic [2:0]  o_mem_funct3,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef enum logic {
    IDLE     = 1'b0,
    DBG_RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        dbg_req;
  logic        cpu_gnt;
  logic        dbg_gnt;
  logic        tie_dbg_wins;

`ifdef LSU_ARB_RR_EN
  // 1 when debug won the most recent tie
  logic last_dbg_q, last_dbg_d;
`else
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;
`endif

  // State registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      dbg_rdata_q <= '0;
`ifdef LSU_ARB_RR_EN
      last_dbg_q  <= 1'b1;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
`ifdef LSU_ARB_RR_EN
      last_dbg_q  <= last_dbg_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  // Grant, FSM next state and port steering
  always_comb begin
    state_d      = state_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_req      = 1'b0;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
    o_dbg_rvalid = 1'b0;
    o_dbg_rdata  = dbg_rdata_q;
`ifdef LSU_ARB_RR_EN
    last_dbg_d   = last_dbg_q;
    tie_dbg_wins = ~last_dbg_q;
`else
    starve_d     = starve_q;
    tie_dbg_wins = (starve_q == CNT_W'(STARVE_MAX));
`endif

    if (i_reset) begin
      // Debug cannot be accepted while its read response is on the bus
      dbg_req = i_dbg_valid && (state_q == IDLE);

      if (i_cpu_req && dbg_req) begin
        dbg_gnt = tie_dbg_wins;
        cpu_gnt = ~tie_dbg_wins;
`ifdef LSU_ARB_RR_EN
        last_dbg_d = tie_dbg_wins;
`endif
      end else begin
        cpu_gnt = i_cpu_req;
        dbg_gnt = dbg_req;
      end

`ifndef LSU_ARB_RR_EN
      // Counts consecutive lost cycles; a withdrawn request restarts it
      if (!i_dbg_valid || dbg_gnt) begin
        starve_d = '0;
      end else if (starve_q != CNT_W'(STARVE_MAX)) begin
        starve_d = starve_q + CNT_W'(1);
      end
`endif

      case (state_q)
        IDLE: begin
          if (dbg_gnt && !i_dbg_wren) begin
            state_d = DBG_RESP;
          end
        end
        DBG_RESP: begin
          state_d      = IDLE;
          o_dbg_rvalid = 1'b1;
          o_dbg_rdata  = i_mem_rdata;
          dbg_rdata_d  = i_mem_rdata;
        end
        default: state_d = IDLE;
      endcase
    end

    // Address stays on the CPU when nobody is granted
    o_mem_addr   = i_cpu_addr;
    o_mem_wdata  = i_cpu_wdata;
    o_mem_funct3 = i_cpu_funct3;
    o_mem_wren   = 1'b0;
    if (dbg_gnt) begin
      o_mem_addr   = i_dbg_addr;
      o_mem_wdata  = i_dbg_wdata;
      o_mem_funct3 = FUNCT3_WORD;
      o_mem_wren   = i_dbg_wren;
    end else if (cpu_gnt) begin
      o_mem_wren   = i_cpu_wren;
    end

    o_dbg_ready = dbg_gnt;
    o_cpu_stall = i_reset && i_cpu_req && !cpu_gnt;
  end

  // Load data timing is aligned by the pipeline, not here
  assign o_cpu_rdata = i_mem_rdata;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
module tb_lsu_port_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cpu_req, i_cpu_wren;
  logic [31:0] i_cpu_addr, i_cpu_wdata;
  logic [2:0]  i_cpu_funct3;
  logic [31:0] o_cpu_rdata;
  logic        o_cpu_stall;
  logic        i_dbg_valid, o_dbg_ready, i_dbg_wren;
  logic [31:0] i_dbg_addr, i_dbg_wdata;
  logic [31:0] o_dbg_rdata;
  logic        o_dbg_rvalid;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        o_mem_wren;
  logic [2:0]  o_mem_funct3;
  logic [31:0] i_mem_rdata;

  always #5 clk = ~clk;

  lsu_port_arbiter #(.STARVE_MAX(8)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cpu_req(i_cpu_req), .i_cpu_wren(i_cpu_wren), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .i_cpu_funct3(i_cpu_funct3),
    .o_cpu_rdata(o_cpu_rdata), .o_cpu_stall(o_cpu_stall),
    .i_dbg_valid(i_dbg_valid), .o_dbg_ready(o_dbg_ready), .i_dbg_wren(i_dbg_wren),
    .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_rdata(o_dbg_rdata), .o_dbg_rvalid(o_dbg_rvalid),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wren(o_mem_wren),
    .o_mem_funct3(o_mem_funct3), .i_mem_rdata(i_mem_rdata)
  );

  // LSU memory: write at the edge, registered read one cycle after address
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (o_mem_wren) mem[o_mem_addr[9:2]] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr[9:2]];
  end

  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_cpu_req = 1'b0; i_cpu_wren = 1'b0; i_cpu_funct3 = 3'b010;
    i_dbg_valid = 1'b0; i_dbg_wren = 1'b0;
  endtask

  task automatic cpu_drive(input logic wren, input logic [31:0] addr, input logic [31:0] wdata);
    i_cpu_req = 1'b1; i_cpu_wren = wren; i_cpu_addr = addr; i_cpu_wdata = wdata;
    i_cpu_funct3 = 3'b010;
  endtask

  task automatic dbg_drive(input logic wren, input logic [31:0] addr, input logic [31:0] wdata);
    i_dbg_valid = 1'b1; i_dbg_wren = wren; i_dbg_addr = addr; i_dbg_wdata = wdata;
  endtask

  // Issue one uncontested debug read and queue its expected word
  task automatic issue_dbg_read(input logic [31:0] addr);
    dbg_drive(1'b0, addr, 32'h0);
    exp_q.push_back(ref_mem[addr[9:2]]);
    next_cycle;
    idle_inputs;
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    cpu_drive(1'b1, 32'h200, 32'h1111_1111);
    dbg_drive(1'b1, 32'h100, 32'h2222_2222);
    next_cycle;
    next_cycle;
    @(negedge clk);
    n_cmp++; if (o_mem_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", o_mem_wren); end
    n_cmp++; if (o_dbg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", o_dbg_ready); end
    n_cmp++; if (o_cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", o_cpu_stall); end
    n_cmp++; if (o_dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", o_dbg_rvalid); end
    n_cmp++; if (o_dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", o_dbg_rdata); end
    idle_inputs;
    i_reset = 1'b1;
    next_cycle;
  endtask

  task automatic test_dbg_write;
    i_cpu_addr = 32'h200;
    dbg_drive(1'b1, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    n_cmp++; if (o_dbg_ready !== 1'b1) begin n_err++; $display("FAIL dw_ready: got %b want 1", o_dbg_ready); end
    n_cmp++; if (o_mem_wren !== 1'b1) begin n_err++; $display("FAIL dw_wren: got %b want 1", o_mem_wren); end
    n_cmp++; if (o_mem_funct3 !== 3'b010) begin n_err++; $display("FAIL dw_funct3: got %b want 010", o_mem_funct3); end
    n_cmp++; if (o_cpu_stall !== 1'b0) begin n_err++; $display("FAIL dw_stall: got %b want 0", o_cpu_stall); end
    n_cmp++; if (o_mem_addr !== 32'h100) begin n_err++; $display("FAIL dw_addr: got %h want 100", o_mem_addr); end
    n_cmp++; if (o_mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dw_wdata: got %h want deadbeef", o_mem_wdata); end
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    next_cycle;
    idle_inputs;
    @(negedge clk);
    n_cmp++; if (o_dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL dw_no_rvalid: got %b want 0", o_dbg_rvalid); end
    next_cycle;
  endtask

  task automatic test_dbg_read;
    logic [31:0] exp;
    dbg_drive(1'b0, 32'h100, 32'h0);
    exp_q.push_back(ref_mem[32'h100 >> 2]);
    @(negedge clk);
    n_cmp++; if (o_dbg_ready !== 1'b1) begin n_err++; $display("FAIL dr_ready: got %b want 1", o_dbg_ready); end
    n_cmp++; if (o_mem_wren !== 1'b0) begin n_err++; $display("FAIL dr_wren: got %b want 0", o_mem_wren); end
    next_cycle;
    // Response cycle: CPU load proceeds, a new debug write must wait
    cpu_drive(1'b0, 32'h200, 32'h0);
    i_cpu_funct3 = 3'b100;
    dbg_drive(1'b1, 32'h104, 32'h1234_5678);
    @(negedge clk);
    n_cmp++; if (o_dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL dr_rvalid: got %b want 1", o_dbg_rvalid); end
    n_cmp++; if (o_dbg_ready !== 1'b0) begin n_err++; $display("FAIL dr_resp_ready: got %b want 0", o_dbg_ready); end
    n_cmp++; if (o_cpu_stall !== 1'b0) begin n_err++; $display("FAIL dr_resp_stall: got %b want 0", o_cpu_stall); end
    n_cmp++; if (o_mem_addr !== 32'h200) begin n_err++; $display("FAIL dr_resp_addr: got %h want 200", o_mem_addr); end
    n_cmp++; if (o_mem_funct3 !== 3'b100) begin n_err++; $display("FAIL dr_resp_funct3: got %b want 100", o_mem_funct3); end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_cmp++; if (o_dbg_rdata !== exp) begin n_err++; $display("FAIL dr_rdata: got %h want %h", o_dbg_rdata, exp); end
    next_cycle;
    i_cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_dbg_ready !== 1'b1) begin n_err++; $display("FAIL dr_next_ready: got %b want 1", o_dbg_ready); end
    n_cmp++; if (o_mem_wren !== 1'b1 || o_mem_addr !== 32'h104) begin n_err++; $display("FAIL dr_next_write: got wren %b addr %h want 1 104", o_mem_wren, o_mem_addr); end
    n_cmp++; if (o_dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL dr_rvalid_drop: got %b want 0", o_dbg_rvalid); end
    n_cmp++; if (o_dbg_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dr_hold: got %h want deadbeef", o_dbg_rdata); end
    ref_mem[32'h104 >> 2] = 32'h1234_5678;
    next_cycle;
    idle_inputs;
    issue_dbg_read(32'h104);
    @(negedge clk);
    n_cmp++; if (o_dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL dr2_rvalid: got %b want 1", o_dbg_rvalid); end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_cmp++; if (o_dbg_rdata !== exp) begin n_err++; $display("FAIL dr2_rdata: got %h want %h", o_dbg_rdata, exp); end
    next_cycle;
  endtask

  task automatic test_cpu_access;
    cpu_drive(1'b1, 32'h200, 32'hCAFE_F00D);
    @(negedge clk);
    n_cmp++; if (o_mem_wren !== 1'b1 || o_mem_addr !== 32'h200 || o_mem_wdata !== 32'hCAFE_F00D)
      begin n_err++; $display("FAIL cpu_store: got wren %b addr %h data %h want 1 200 cafef00d", o_mem_wren, o_mem_addr, o_mem_wdata); end
    n_cmp++; if (o_cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_store_stall: got %b want 0", o_cpu_stall); end
    ref_mem[32'h200 >> 2] = 32'hCAFE_F00D;
    next_cycle;
    cpu_drive(1'b0, 32'h200, 32'h0);
    @(negedge clk);
    n_cmp++; if (o_mem_wren !== 1'b0) begin n_err++; $display("FAIL cpu_load_wren: got %b want 0", o_mem_wren); end
    next_cycle;
    i_cpu_req = 1'b0;
    i_cpu_addr = 32'h204;
    @(negedge clk);
    n_cmp++; if (o_cpu_rdata !== ref_mem[32'h200 >> 2]) begin n_err++; $display("FAIL cpu_rdata: got %h want %h", o_cpu_rdata, ref_mem[32'h200 >> 2]); end
    n_cmp++; if (o_mem_addr !== 32'h204 || o_mem_wren !== 1'b0) begin n_err++; $display("FAIL no_grant: got addr %h wren %b want 204 0", o_mem_addr, o_mem_wren); end
    next_cycle;
  endtask

  task automatic test_arbitration;
    logic        exp_dbg;
    logic [31:0] exp;
    // A request that loses one tie and then withdraws must leave no trace
    cpu_drive(1'b0, 32'h200, 32'h0);
    dbg_drive(1'b1, 32'h1C0, 32'h0000_0BAD);
`ifdef LSU_ARB_RR_EN
    @(negedge clk);
    n_cmp++; if (o_dbg_ready !== 1'b0) begin n_err++; $display("FAIL rr_first_tie: got ready %b want 0", o_dbg_ready); end
    next_cycle;
`else
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (o_dbg_ready !== 1'b0) begin n_err++; $display("FAIL pre_tie%0d: got ready %b want 0", c, o_dbg_ready); end
      next_cycle;
    end
`endif
    i_dbg_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_mem_wren !== 1'b0) begin n_err++; $display("FAIL withdraw_wren: got %b want 0", o_mem_wren); end
    next_cycle;
    dbg_drive(1'b1, 32'h180, 32'hA5A5_0001);
`ifdef LSU_ARB_RR_EN
    // Previous tie went to CPU, so alternation resumes with debug
    for (int c = 0; c < 6; c++) begin
      exp_dbg = ((c % 2) == 0);
`else
    // Two starvation rounds: eight CPU wins, then debug forced through
    for (int c = 0; c < 18; c++) begin
      exp_dbg = ((c % 9) == 8);
`endif
      @(negedge clk);
      n_cmp++; if (o_dbg_ready !== exp_dbg) begin n_err++; $display("FAIL arb_ready c%0d: got %b want %b", c, o_dbg_ready, exp_dbg); end
      n_cmp++; if (o_cpu_stall !== exp_dbg) begin n_err++; $display("FAIL arb_stall c%0d: got %b want %b", c, o_cpu_stall, exp_dbg); end
      n_cmp++; if (o_mem_addr !== (exp_dbg ? 32'h180 : 32'h200)) begin n_err++; $display("FAIL arb_addr c%0d: got %h", c, o_mem_addr); end
      if (exp_dbg) ref_mem[32'h180 >> 2] = i_dbg_wdata;
      next_cycle;
      if (exp_dbg) i_dbg_wdata = i_dbg_wdata + 32'h1;
    end
    idle_inputs;
    next_cycle;
    for (int k = 0; k < 2; k++) begin
      issue_dbg_read(k == 0 ? 32'h180 : 32'h1C0);
      @(negedge clk);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      n_cmp++; if (o_dbg_rvalid !== 1'b1 || o_dbg_rdata !== exp) begin n_err++; $display("FAIL arb_readback%0d: got %b %h want 1 %h", k, o_dbg_rvalid, o_dbg_rdata, exp); end
      next_cycle;
    end
  endtask

  task automatic test_stalled_store;
    logic [31:0] exp;
    cpu_drive(1'b0, 32'h200, 32'h0);
    dbg_drive(1'b1, 32'h140, 32'h0BAD_F00D);
`ifndef LSU_ARB_RR_EN
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (o_dbg_ready !== 1'b0) begin n_err++; $display("FAIL ss_pre%0d: got ready %b want 0", c, o_dbg_ready); end
      next_cycle;
    end
`endif
    cpu_drive(1'b1, 32'h300, 32'h600D_CAFE);
    @(negedge clk);
    n_cmp++; if (o_cpu_stall !== 1'b1 || o_dbg_ready !== 1'b1) begin n_err++; $display("FAIL ss_stall: got stall %b ready %b want 1 1", o_cpu_stall, o_dbg_ready); end
    n_cmp++; if (o_mem_addr !== 32'h140 || o_mem_wdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL ss_dbg_write: got %h %h", o_mem_addr, o_mem_wdata); end
    ref_mem[32'h140 >> 2] = 32'h0BAD_F00D;
    next_cycle;
    i_dbg_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_cpu_stall !== 1'b0 || o_mem_wren !== 1'b1) begin n_err++; $display("FAIL ss_retry: got stall %b wren %b want 0 1", o_cpu_stall, o_mem_wren); end
    n_cmp++; if (o_mem_addr !== 32'h300 || o_mem_wdata !== 32'h600D_CAFE) begin n_err++; $display("FAIL ss_retry_data: got %h %h", o_mem_addr, o_mem_wdata); end
    ref_mem[32'h300 >> 2] = 32'h600D_CAFE;
    next_cycle;
    cpu_drive(1'b0, 32'h300, 32'h0);
    next_cycle;
    i_cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_cpu_rdata !== ref_mem[32'h300 >> 2]) begin n_err++; $display("FAIL ss_load: got %h want %h", o_cpu_rdata, ref_mem[32'h300 >> 2]); end
    next_cycle;
    issue_dbg_read(32'h140);
    @(negedge clk);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_cmp++; if (o_dbg_rvalid !== 1'b1 || o_dbg_rdata !== exp) begin n_err++; $display("FAIL ss_readback: got %b %h want 1 %h", o_dbg_rvalid, o_dbg_rdata, exp); end
    next_cycle;
  endtask

  task automatic test_reset_in_resp;
    logic [31:0] exp;
    dbg_drive(1'b0, 32'h100, 32'h0);
    @(negedge clk);
    n_cmp++; if (o_dbg_ready !== 1'b1) begin n_err++; $display("FAIL rr_accept: got %b want 1", o_dbg_ready); end
    next_cycle;
    idle_inputs;
    i_reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rresp_rvalid_in_reset: got %b want 0", o_dbg_rvalid); end
    next_cycle;
    i_reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rresp_rvalid_after: got %b want 0", o_dbg_rvalid); end
    n_cmp++; if (o_dbg_rdata !== 32'h0) begin n_err++; $display("FAIL rresp_rdata: got %h want 0", o_dbg_rdata); end
    next_cycle;
    issue_dbg_read(32'h104);
    @(negedge clk);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_cmp++; if (o_dbg_rvalid !== 1'b1 || o_dbg_rdata !== exp) begin n_err++; $display("FAIL rresp_idle_read: got %b %h want 1 %h", o_dbg_rvalid, o_dbg_rdata, exp); end
    next_cycle;
  endtask

  initial begin
    i_reset = 1'b0;
    i_cpu_addr = '0; i_cpu_wdata = '0; i_dbg_addr = '0; i_dbg_wdata = '0;
    idle_inputs;
    test_reset;
    test_dbg_write;
    test_dbg_read;
    test_cpu_access;
    test_arbitration;
    test_stalled_store;
    test_reset_in_resp;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
